// File: rtl/bster_mem_pkg.sv
// rtl/bster_mem_pkg.sv - shared types, defaults and round-robin pick helper for the BST memory arbiter
package bster_mem_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_ISSUE
    } arb_state_t;

    localparam int DEF_NB_REQ          = 4;
    localparam int DEF_MAX_OUTSTANDING = 8;
    localparam int MAX_NB_REQ          = 8;

    // First set bit of mask scanning ptr, ptr+1, ... modulo n (n <= 8, ptr < n).
    function automatic logic [2:0] rr_pick(input logic [7:0] mask, input logic [2:0] ptr,
                                           input logic [3:0] n);
        logic [2:0] pick;
        logic       found;
        logic [3:0] j;
        pick  = 3'd0;
        found = 1'b0;
        for (int k = 0; k < MAX_NB_REQ; k++) begin
            j = {1'b0, ptr} + 4'(k);
            if (j >= n) begin
                j = j - n;
            end
            if (!found && (4'(k) < n) && mask[j[2:0]]) begin
                pick  = j[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory-driver signal bundle for mem_arbiter
interface mem_arbiter_if
    import bster_mem_pkg::*;
#(
    parameter int NB_REQ         = DEF_NB_REQ,
    parameter int RAM_ADDR_WIDTH = 16,
    parameter int RAM_DATA_WIDTH = 32
);
    logic [NB_REQ-1:0]                req_valid;
    logic [NB_REQ-1:0]                req_ready;
    logic [NB_REQ-1:0]                req_rd;
    logic [NB_REQ-1:0]                req_wr;
    logic [NB_REQ*RAM_ADDR_WIDTH-1:0] req_addr;
    logic [NB_REQ*RAM_DATA_WIDTH-1:0] req_wr_data;
    logic [NB_REQ-1:0]                req_rd_valid;
    logic [NB_REQ-1:0]                req_rd_ready;
    logic [RAM_DATA_WIDTH-1:0]        req_rd_data;
    logic                             mem_valid;
    logic                             mem_ready;
    logic                             mem_rd;
    logic                             mem_wr;
    logic [RAM_ADDR_WIDTH-1:0]        mem_addr;
    logic [RAM_DATA_WIDTH-1:0]        mem_wr_data;
    logic                             mem_rd_valid;
    logic                             mem_rd_ready;
    logic [RAM_DATA_WIDTH-1:0]        mem_rd_data;

    // Arbiter view: serves the requesters, masters the memory driver port.
    modport master (
        input  req_valid, req_rd, req_wr, req_addr, req_wr_data, req_rd_ready,
        input  mem_ready, mem_rd_valid, mem_rd_data,
        output req_ready, req_rd_valid, req_rd_data,
        output mem_valid, mem_rd, mem_wr, mem_addr, mem_wr_data, mem_rd_ready
    );

    modport slave (
        output req_valid, req_rd, req_wr, req_addr, req_wr_data, req_rd_ready,
        output mem_ready, mem_rd_valid, mem_rd_data,
        input  req_ready, req_rd_valid, req_rd_data,
        input  mem_valid, mem_rd, mem_wr, mem_addr, mem_wr_data, mem_rd_ready
    );
endinterface

// File: rtl/mem_arb_order_fifo.sv
// rtl/mem_arb_order_fifo.sv - order FIFO of requester indices with registered full/empty flags
module mem_arb_order_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_d;
            full    <= (count_d == CW'(DEPTH));
            empty   <= (count_d == '0);
        end
    end

    always_ff @(posedge aclk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port among NB_REQ requesters
// MEM_ARBITER_FIXED_PRIO_EN: lowest eligible index wins instead of round-robin.
module mem_arbiter
    import bster_mem_pkg::*;
#(
    parameter int NB_REQ          = DEF_NB_REQ,
    parameter int RAM_ADDR_WIDTH  = 16,
    parameter int RAM_DATA_WIDTH  = 32,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int IDX_WIDTH       = $clog2(NB_REQ)
) (
    input logic           aclk,
    input logic           areset,
    mem_arbiter_if.master bus
);
    arb_state_t                state_q;
    arb_state_t                state_d;
    logic [NB_REQ-1:0]         eligible;
    logic [IDX_WIDTH-1:0]      winner;
    logic                      grant;
    logic [NB_REQ-1:0]         req_ready_d;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic [IDX_WIDTH-1:0]      head;
    logic                      mem_rd_ready_d;
    logic                      mem_rd_q;
    logic                      mem_wr_q;
    logic [RAM_ADDR_WIDTH-1:0] mem_addr_q;
    logic [RAM_DATA_WIDTH-1:0] mem_wr_data_q;
    logic [RAM_ADDR_WIDTH-1:0] addr_arr  [NB_REQ];
    logic [RAM_DATA_WIDTH-1:0] wdata_arr [NB_REQ];

    for (genvar i = 0; i < NB_REQ; i++) begin : g_slice
        assign addr_arr[i]  = bus.req_addr[i*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
        assign wdata_arr[i] = bus.req_wr_data[i*RAM_DATA_WIDTH +: RAM_DATA_WIDTH];
    end

    // Registered full flag: a pop in the same cycle does not re-enable reads.
    assign eligible = bus.req_valid & ~(bus.req_rd & {NB_REQ{fifo_full}});

`ifdef MEM_ARBITER_FIXED_PRIO_EN
    assign winner = IDX_WIDTH'(rr_pick(8'(eligible), 3'd0, 4'(NB_REQ)));
`else
    logic [IDX_WIDTH-1:0] rr_ptr;

    assign winner = IDX_WIDTH'(rr_pick(8'(eligible), 3'(rr_ptr), 4'(NB_REQ)));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= (winner == IDX_WIDTH'(NB_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant       = 1'b0;
        req_ready_d = '0;
        case (state_q)
            ARB_IDLE: begin
                if (|eligible) begin
                    grant               = 1'b1;
                    req_ready_d[winner] = 1'b1;
                    state_d             = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (bus.mem_ready) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
        end else if (grant) begin
            mem_rd_q      <= bus.req_rd[winner];
            mem_wr_q      <= bus.req_wr[winner];
            mem_addr_q    <= addr_arr[winner];
            mem_wr_data_q <= wdata_arr[winner];
        end
    end

    assign bus.req_ready   = req_ready_d;
    assign bus.mem_valid   = (state_q == ARB_ISSUE);
    assign bus.mem_rd      = mem_rd_q;
    assign bus.mem_wr      = mem_wr_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wr_data = mem_wr_data_q;

    // A read+write command is tracked as a read.
    assign fifo_push = grant & bus.req_rd[winner];
    assign fifo_pop  = bus.mem_rd_valid & mem_rd_ready_d;

    mem_arb_order_fifo #(
        .WIDTH (IDX_WIDTH),
        .DEPTH (MAX_OUTSTANDING)
    ) u_order_fifo (
        .aclk      (aclk),
        .areset    (areset),
        .push      (fifo_push),
        .push_data (winner),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign mem_rd_ready_d   = ~fifo_empty & bus.req_rd_ready[head];
    assign bus.mem_rd_ready = mem_rd_ready_d;
    assign bus.req_rd_valid = (bus.mem_rd_valid & ~fifo_empty) ? (NB_REQ'(1) << head) : '0;
    assign bus.req_rd_data  = bus.mem_rd_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized and directed checks of mem_arbiter against a queue-based model
module tb_mem_arbiter;
    localparam int NB = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int MO = 2;
`ifdef MEM_ARBITER_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    mem_arbiter_if #(.NB_REQ(NB), .RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW)) bus ();

    mem_arbiter #(
        .NB_REQ          (NB),
        .RAM_ADDR_WIDTH  (AW),
        .RAM_DATA_WIDTH  (DW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    logic [AW-1:0] t_addr  [NB];
    logic [DW-1:0] t_wdata [NB];
    assign bus.req_addr    = {t_addr[3], t_addr[2], t_addr[1], t_addr[0]};
    assign bus.req_wr_data = {t_wdata[3], t_wdata[2], t_wdata[1], t_wdata[0]};

    int checks = 0;
    int failures = 0;

    // Reference model: a busy flag with the held command, a pointer and a queue of owners.
    bit      m_busy;
    int      m_ptr;
    int      m_q[$];
    logic    m_rd, m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    logic [NB-1:0] obs_ready, obs_rdv;
    logic          obs_mrr, obs_mvalid, obs_mrd, obs_mwr;
    logic [AW-1:0] obs_maddr;
    logic [DW-1:0] obs_mdata, obs_rdata;
    int            n_hs;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit elig(input int i);
        return bus.req_valid[i] && !(bus.req_rd[i] && (m_q.size() == MO));
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_ptr  = 0;
        m_q.delete();
    endtask

    task automatic clear_inputs();
        bus.req_valid    = '0;
        bus.req_rd       = '0;
        bus.req_wr       = '0;
        bus.req_rd_ready = '0;
        bus.mem_ready    = 1'b0;
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = '0;
        for (int i = 0; i < NB; i++) begin
            t_addr[i]  = '0;
            t_wdata[i] = '0;
        end
    endtask

    task automatic do_reset();
        areset = 1'b1;
        clear_inputs();
        model_reset();
        @(posedge aclk);
        @(posedge aclk);
        #1;
        areset = 1'b0;
    endtask

    // One clock: inputs are already driven; check at negedge, advance the model at posedge.
    task automatic cycle();
        int w, idx;
        bit any, do_pop, hs;
        logic [NB-1:0] exp_ready, exp_rdv;
        logic exp_mrr;
        logic n_rd, n_wr;
        logic [AW-1:0] n_addr;
        logic [DW-1:0] n_data;
        @(negedge aclk);
        any = 1'b0;
        w = 0;
        exp_ready = '0;
        if (!m_busy) begin
            for (int k = 0; k < NB; k++) begin
                idx = FIXED ? k : (m_ptr + k) % NB;
                if (!any && elig(idx)) begin
                    any = 1'b1;
                    w = idx;
                end
            end
            if (any) exp_ready[w] = 1'b1;
        end
        exp_rdv = '0;
        exp_mrr = 1'b0;
        if (m_q.size() > 0) begin
            if (bus.mem_rd_valid) exp_rdv[m_q[0]] = 1'b1;
            exp_mrr = bus.req_rd_ready[m_q[0]];
        end
        obs_ready  = bus.req_ready;
        obs_rdv    = bus.req_rd_valid;
        obs_mrr    = bus.mem_rd_ready;
        obs_rdata  = bus.req_rd_data;
        obs_mvalid = bus.mem_valid;
        obs_mrd    = bus.mem_rd;
        obs_mwr    = bus.mem_wr;
        obs_maddr  = bus.mem_addr;
        obs_mdata  = bus.mem_wr_data;
        chk("req_ready", obs_ready, exp_ready);
        chk("mem_valid", obs_mvalid, m_busy);
        if (m_busy) begin
            chk("mem_rd", obs_mrd, m_rd);
            chk("mem_wr", obs_mwr, m_wr);
            chk("mem_addr", obs_maddr, m_addr);
            chk("mem_wr_data", obs_mdata, m_data);
        end
        chk("req_rd_valid", obs_rdv, exp_rdv);
        chk("mem_rd_ready", obs_mrr, exp_mrr);
        if (|exp_rdv) chk("req_rd_data", obs_rdata, bus.mem_rd_data);
        do_pop = bus.mem_rd_valid && exp_mrr;
        hs     = m_busy && bus.mem_ready;
        n_rd   = bus.req_rd[w];
        n_wr   = bus.req_wr[w];
        n_addr = t_addr[w];
        n_data = t_wdata[w];
        if (obs_mvalid && bus.mem_ready) n_hs++;
        @(posedge aclk);
        if (do_pop) void'(m_q.pop_front());
        if (any) begin
            m_busy = 1'b1;
            m_rd   = n_rd;
            m_wr   = n_wr;
            m_addr = n_addr;
            m_data = n_data;
            m_ptr  = (w + 1) % NB;
            if (n_rd) m_q.push_back(w);
        end else if (hs) begin
            m_busy = 1'b0;
        end
        #1;
    endtask

    initial begin : main
        int ng, last, g0, g3;
        clear_inputs();
        do_reset();

        // Reset state.
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_mem_valid", bus.mem_valid, 0);
        chk("rst_mem_rd_wr", {bus.mem_rd, bus.mem_wr}, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wr_data", bus.mem_wr_data, 0);
        chk("rst_mem_rd_ready", bus.mem_rd_ready, 0);
        chk("rst_req_rd_valid", bus.req_rd_valid, 0);

        // Single write from requester 0.
        n_hs = 0;
        bus.mem_ready = 1'b1;
        bus.req_valid = 4'b0001;
        bus.req_wr    = 4'b0001;
        t_addr[0]     = 16'h0010;
        t_wdata[0]    = 32'hDEADBEEF;
        cycle();
        chk("t1_ready", obs_ready, 4'b0001);
        bus.req_valid = '0;
        cycle();
        chk("t1_mem_valid", obs_mvalid, 1);
        chk("t1_mem_wr", {obs_mrd, obs_mwr}, 2'b01);
        chk("t1_mem_addr", obs_maddr, 16'h0010);
        chk("t1_mem_data", obs_mdata, 32'hDEADBEEF);
        repeat (3) cycle();
        chk("t1_handshakes", n_hs, 1);

        // All four requesters writing: grant order and spacing.
        do_reset();
        bus.mem_ready = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_wr    = 4'hF;
        ng = 0;
        last = 0;
        for (int c = 0; c < 12; c++) begin
            cycle();
            if (obs_ready != 0) begin
                chk("t2_grant", $clog2(obs_ready), FIXED ? 0 : ng % NB);
                if (ng > 0) chk("t2_spacing", c - last, 2);
                last = c;
                ng++;
            end
        end
        chk("t2_count", ng, 6);

        // In-order read return to requester 2 then requester 1.
        do_reset();
        bus.mem_ready    = 1'b1;
        bus.req_rd_ready = 4'hF;
        bus.req_valid    = 4'b0100;
        bus.req_rd       = 4'b0100;
        t_addr[2]        = 16'h0100;
        cycle();
        chk("t3_grant2", obs_ready, 4'b0100);
        bus.req_valid = '0;
        cycle();
        chk("t3_mem_addr", obs_maddr, 16'h0100);
        bus.req_valid = 4'b0010;
        bus.req_rd    = 4'b0010;
        t_addr[1]     = 16'h0200;
        cycle();
        chk("t3_grant1", obs_ready, 4'b0010);
        bus.req_valid = '0;
        cycle();
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = 32'h0000AAAA;
        cycle();
        chk("t3_rdv_first", obs_rdv, 4'b0100);
        chk("t3_data_first", obs_rdata, 32'h0000AAAA);
        bus.mem_rd_data = 32'h0000BBBB;
        cycle();
        chk("t3_rdv_second", obs_rdv, 4'b0010);
        chk("t3_data_second", obs_rdata, 32'h0000BBBB);
        bus.mem_rd_valid = 1'b0;
        cycle();

        // Order FIFO full: reads stall, writes still arbitrate.
        do_reset();
        bus.mem_ready = 1'b1;
        bus.req_valid = 4'b1001;
        bus.req_rd    = 4'b0001;
        bus.req_wr    = 4'b1000;
        g0 = 0;
        g3 = 0;
        for (int c = 0; c < 12; c++) begin
            cycle();
            if (obs_ready[0]) g0++;
            if (obs_ready[3]) g3++;
        end
        chk("t4_read_grants", g0, 2);
        chk("t4_write_grants", g3, 4);
        bus.req_valid = 4'b0001;
        cycle();
        chk("t4_stalled", obs_ready, 0);
        bus.mem_rd_valid = 1'b1;
        bus.req_rd_ready = 4'hF;
        cycle();
        chk("t4_pop_same_cycle", obs_ready, 0);
        chk("t4_pop_ready", obs_mrr, 1);
        bus.mem_rd_valid = 1'b0;
        cycle();
        chk("t4_third_read", obs_ready, 4'b0001);

        // Stall in ISSUE, then asynchronous reset mid-command.
        do_reset();
        bus.req_valid = 4'b0010;
        bus.req_rd    = 4'b0010;
        t_addr[1]     = 16'h1234;
        cycle();
        chk("t5_grant", obs_ready, 4'b0010);
        bus.req_valid = 4'hF;
        bus.req_rd    = '0;
        bus.req_wr    = 4'hF;
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk("t5_hold_ready", obs_ready, 0);
            chk("t5_hold_valid", obs_mvalid, 1);
            chk("t5_hold_addr", obs_maddr, 16'h1234);
        end
        areset = 1'b1;
        #1;
        chk("t5_async_valid", bus.mem_valid, 0);
        chk("t5_async_addr", bus.mem_addr, 0);
        model_reset();
        @(posedge aclk);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        bus.mem_rd_valid = 1'b1;
        bus.req_rd_ready = 4'hF;
        cycle();
        chk("t5_fifo_empty", obs_mrr, 0);
        chk("t5_no_rdv", obs_rdv, 0);
        chk("t5_ptr_zero", obs_ready, 4'b0001);

        // Backpressure on the head requester's read data.
        do_reset();
        bus.mem_ready = 1'b1;
        bus.req_valid = 4'b0010;
        bus.req_rd    = 4'b0010;
        cycle();
        bus.req_valid = '0;
        cycle();
        bus.req_valid = 4'b0100;
        bus.req_rd    = 4'b0100;
        cycle();
        bus.req_valid = '0;
        cycle();
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = 32'h12345678;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("t6_blocked_ready", obs_mrr, 0);
            chk("t6_blocked_rdv", obs_rdv, 4'b0010);
        end
        bus.req_rd_ready = 4'b0010;
        cycle();
        chk("t6_pop", obs_mrr, 1);
        cycle();
        chk("t6_head_advanced", obs_rdv, 4'b0100);
        chk("t6_head_blocked", obs_mrr, 0);
        bus.mem_rd_valid = 1'b0;

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            bus.req_valid = 4'($urandom);
            bus.req_rd    = 4'($urandom);
            bus.req_wr    = 4'($urandom);
            for (int i = 0; i < NB; i++) begin
                t_addr[i]  = 16'($urandom);
                t_wdata[i] = $urandom;
            end
            bus.mem_ready    = ($urandom_range(0, 3) != 0);
            bus.mem_rd_valid = ($urandom_range(0, 2) == 0);
            bus.mem_rd_data  = $urandom;
            bus.req_rd_ready = 4'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
